srm_controller: RTL and testbench

- Instruction decoder and control FSM for the Simple RISC Machine datapath.
- Latches a 16-bit instruction on a start handshake, then sequences register reads, the shift/ALU stage and register write-back over multiple cycles.
- It is the producer of the 2-bit shift code that the datapath shifter consumes, together with all other datapath load/select strobes.

---
 rtl/srm_pkg.sv | 47 ++++
 rtl/srm_instr_dec.sv | 43 ++++
 rtl/srm_controller.sv | 173 +++++++++++++++++
 tb/tb_srm_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/srm_pkg.sv
// rtl/srm_pkg.sv - shared constants, codes and state encoding for the SRM controller (SRM_ILLEGAL_TRAP_EN adds HALT)
package srm_pkg;
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        CL_ILLEGAL,
        CL_MOV_IMM,
        CL_MOV_REG,
        CL_ALU,
        CL_CMP,
        CL_MVN
    } iclass_e;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
`ifdef SRM_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_e;
endpackage

// File: rtl/srm_instr_dec.sv
// rtl/srm_instr_dec.sv - combinational field extraction, sign extension and class decode of the IR
module srm_instr_dec
    import srm_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0] ir,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [1:0]    sh,
    output logic [2:0]    rm,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5,
    output iclass_e       iclass
);
    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(IW-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(IW-5){ir[4]}}, ir[4:0]};

    always_comb begin
        iclass = CL_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)
                iclass = CL_MOV_IMM;
            else if (op == OP_MOV_REG)
                iclass = CL_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_CMP:  iclass = CL_CMP;
                OP_MVN:  iclass = CL_MVN;
                default: iclass = CL_ALU;
            endcase
        end
    end
endmodule

// File: rtl/srm_controller.sv
// rtl/srm_controller.sv - SRM instruction decoder and control FSM; SRM_ILLEGAL_TRAP_EN traps illegal opcodes in HALT
module srm_controller
    import srm_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    input  logic [IW-1:0] in,
    output logic          w,
    output logic [2:0]    rnum,
    output logic          write,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    aluop,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5,
    output logic          err
);
    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [1:0]    op;
    logic [2:0]    rn, rd, rm;
    logic [1:0]    sh;
    iclass_e       iclass;

    logic       w_q, w_d, write_q, write_d;
    logic [2:0] rnum_q, rnum_d;
    logic [1:0] vsel_q, vsel_d, shift_q, shift_d, aluop_q, aluop_d;
    logic       loada_q, loada_d, loadb_q, loadb_d;
    logic       loadc_q, loadc_d, loads_q, loads_d, asel_q, asel_d;

    srm_instr_dec #(.IW(IW)) u_dec (
        .ir     (ir_q),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .iclass (iclass)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: if (s) begin
                ir_d    = in;
                state_d = S_DECODE;
            end
            S_DECODE: case (iclass)
                CL_MOV_IMM:          state_d = S_WRITE_IMM;
                CL_MOV_REG, CL_MVN:  state_d = S_GET_B;
                CL_ALU, CL_CMP:      state_d = S_GET_A;
`ifdef SRM_ILLEGAL_TRAP_EN
                default:             state_d = S_HALT;
`else
                default:             state_d = S_WAIT;
`endif
            endcase
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = (iclass == CL_CMP) ? S_WAIT : S_WRITE_REG;
`ifdef SRM_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    // Outputs are registered by decoding the next state; the IR only changes on
    // entry to DECODE, where every strobe is 0, so the current IR decode is valid.
    always_comb begin
        w_d     = 1'b0;
        rnum_d  = 3'd0;
        write_d = 1'b0;
        vsel_d  = VSEL_C;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        asel_d  = 1'b0;
        shift_d = SH_NONE;
        aluop_d = ALU_ADD;
        case (state_d)
            S_WAIT: w_d = 1'b1;
            S_WRITE_IMM: begin
                rnum_d  = rn;
                vsel_d  = VSEL_IMM;
                write_d = 1'b1;
            end
            S_GET_A: begin
                rnum_d  = rn;
                loada_d = 1'b1;
            end
            S_GET_B: begin
                rnum_d  = rm;
                loadb_d = 1'b1;
            end
            S_EXEC: begin
                shift_d = sh;
                aluop_d = (iclass == CL_MOV_REG) ? ALU_ADD : op;
                asel_d  = (iclass == CL_MOV_REG) || (iclass == CL_MVN);
                loads_d = (iclass == CL_CMP);
                loadc_d = (iclass != CL_CMP);
            end
            S_WRITE_REG: begin
                rnum_d  = rd;
                write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            w_q     <= 1'b1;
            rnum_q  <= 3'd0;
            write_q <= 1'b0;
            vsel_q  <= VSEL_C;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            shift_q <= SH_NONE;
            aluop_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            w_q     <= w_d;
            rnum_q  <= rnum_d;
            write_q <= write_d;
            vsel_q  <= vsel_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            asel_q  <= asel_d;
            shift_q <= shift_d;
            aluop_q <= aluop_d;
        end
    end

    assign w     = w_q;
    assign rnum  = rnum_q;
    assign write = write_q;
    assign vsel  = vsel_q;
    assign loada = loada_q;
    assign loadb = loadb_q;
    assign loadc = loadc_q;
    assign loads = loads_q;
    assign asel  = asel_q;
    assign bsel  = 1'b0;
    assign shift = shift_q;
    assign aluop = aluop_q;
`ifdef SRM_ILLEGAL_TRAP_EN
    assign err   = (state_q == S_HALT);
`else
    assign err   = 1'b0;
`endif
endmodule

// File: tb/tb_srm_controller.sv
// tb/tb_srm_controller.sv - directed self-checking bench for srm_controller (honours SRM_ILLEGAL_TRAP_EN)
module tb_srm_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] in_i = 16'h0000;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0]  rnum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8, sximm5;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    srm_controller dut (
        .clk(clk), .rst_n(rst_n), .s(s), .in(in_i), .w(w), .rnum(rnum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .aluop(aluop),
        .sximm8(sximm8), .sximm5(sximm5), .err(err)
    );

    // {w, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, aluop}
    function automatic logic [16:0] mk(input logic wv, input logic [2:0] rn, input logic wr,
                                       input logic [1:0] vs, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as,
                                       input logic [1:0] sh, input logic [1:0] al);
        return {wv, rn, wr, vs, la, lb, lc, ls, as, 1'b0, sh, al};
    endfunction

    function automatic logic [16:0] obs();
        return {w, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, aluop};
    endfunction

    localparam logic [16:0] IDLE = 17'h10000;
    localparam logic [16:0] ZERO = 17'h00000;

    // Drives instr with s for one edge; returns at the negedge of cycle 1 (DECODE).
    task automatic issue(input logic [15:0] instr);
        @(negedge clk);
        in_i = instr;
        s    = 1'b1;
        @(negedge clk);
        s    = 1'b0;
        in_i = 16'hFFFF;
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs() !== IDLE || err !== 1'b0 || sximm8 !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_state ctl=%h err=%b sximm8=%h required ctl=%h err=0 sximm8=0000", obs(), err, sximm8, IDLE);
        end
        issue(16'hA150);
        @(negedge clk);
        n_checks++;
        if (obs() !== mk(0, 3'd1, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00)) begin
            n_fails++;
            $display("FAIL reset_get_a ctl=%h required ctl=%h", obs(), mk(0, 3'd1, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        end
        in_i  = 16'hD007;
        s     = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== IDLE || sximm8 !== 16'h0 || sximm5 !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_async ctl=%h sximm8=%h sximm5=%h required ctl=%h imm=0000", obs(), sximm8, sximm5, IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (write !== 1'b0 || w !== 1'b1) begin
                n_fails++;
                $display("FAIL reset_hold cyc=%0d write=%b w=%b required write=0 w=1", i, write, w);
            end
        end
        s     = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_mov_imm(input logic [15:0] instr, input logic [15:0] imm);
        logic [16:0] exp [3];
        exp = '{ZERO, mk(0, 3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00), IDLE};
        issue(instr);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== exp[i] || sximm8 !== imm) begin
                n_fails++;
                $display("FAIL mov_imm_%h cyc=%0d ctl=%h sximm8=%h required ctl=%h sximm8=%h", instr, i + 1, obs(), sximm8, exp[i], imm);
            end
        end
    endtask

    task automatic test_mov_reg();
        logic [16:0] exp [5];
        exp = '{ZERO,
                mk(0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00),
                mk(0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 1, 2'b01, 2'b00),
                mk(0, 3'd1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00),
                IDLE};
        issue(16'hC028);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fails++;
                $display("FAIL mov_reg cyc=%0d ctl=%h required ctl=%h", i + 1, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_alu(input logic [15:0] instr, input logic [2:0] ra, input logic [2:0] rb,
                            input logic [2:0] rdst, input logic [1:0] sh, input logic [1:0] al);
        logic [16:0] exp [6];
        exp = '{ZERO,
                mk(0, ra, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00),
                mk(0, rb, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00),
                mk(0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 0, sh, al),
                mk(0, rdst, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00),
                IDLE};
        issue(instr);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fails++;
                $display("FAIL alu_%h cyc=%0d ctl=%h required ctl=%h", instr, i + 1, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [16:0] exp [5];
        exp = '{ZERO,
                mk(0, 3'd1, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00),
                mk(0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00),
                mk(0, 3'd0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b11, 2'b01),
                IDLE};
        issue(16'hA918);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fails++;
                $display("FAIL cmp cyc=%0d ctl=%h required ctl=%h", i + 1, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_mvn();
        logic [16:0] exp [5];
        exp = '{ZERO,
                mk(0, 3'd2, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00),
                mk(0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 1, 2'b00, 2'b11),
                mk(0, 3'd3, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00),
                IDLE};
        issue(16'hB862);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fails++;
                $display("FAIL mvn cyc=%0d ctl=%h required ctl=%h", i + 1, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp [7];
        logic [15:0] imm [7];
        exp = '{ZERO, mk(0, 3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00), IDLE,
                ZERO, mk(0, 3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00), IDLE, IDLE};
        imm = '{16'h0007, 16'h0007, 16'h0007, 16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9};
        @(negedge clk);
        in_i = 16'hD007;
        s    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) in_i = 16'hD0F9;
            if (i == 3) in_i = 16'hE000;
            if (i == 5) s = 1'b0;
            n_checks++;
            if (obs() !== exp[i] || sximm8 !== imm[i]) begin
                n_fails++;
                $display("FAIL back_to_back cyc=%0d ctl=%h sximm8=%h required ctl=%h sximm8=%h", i + 1, obs(), sximm8, exp[i], imm[i]);
            end
        end
    endtask

    task automatic test_illegal();
        issue(16'hE000);
`ifdef SRM_ILLEGAL_TRAP_EN
        s = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== ZERO || err !== (i > 0)) begin
                n_fails++;
                $display("FAIL illegal_halt cyc=%0d ctl=%h err=%b required ctl=%h err=%b", i + 1, obs(), err, ZERO, (i > 0));
            end
        end
        s     = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== IDLE || err !== 1'b0) begin
            n_fails++;
            $display("FAIL illegal_reset ctl=%h err=%b required ctl=%h err=0", obs(), err, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
`else
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (obs() !== (i == 0 ? ZERO : IDLE) || err !== 1'b0) begin
                n_fails++;
                $display("FAIL illegal_nop cyc=%0d ctl=%h err=%b required ctl=%h err=0", i + 1, obs(), err, (i == 0 ? ZERO : IDLE));
            end
        end
`endif
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        test_reset();
        test_mov_imm(16'hD007, 16'h0007);
        test_mov_imm(16'hD0F9, 16'hFFF9);
        n_checks++;
        if (sximm5 !== 16'hFFF9) begin
            n_fails++;
            $display("FAIL sximm5 value=%h required=FFF9", sximm5);
        end
        test_mov_reg();
        test_alu(16'hA150, 3'd1, 3'd0, 3'd2, 2'b10, 2'b00);
        test_alu(16'hB281, 3'd2, 3'd1, 3'd4, 2'b00, 2'b10);
        test_cmp();
        test_mvn();
        test_back_to_back();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
